// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, counter/step types and the timing
// bundle registered by the frame controller.
package vga_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned STEP_W = 3;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [STEP_W-1:0] step_t;

  localparam step_t STEP_MAX = '1;

  typedef struct packed {
    cnt_t x;
    cnt_t y;
    logic active;
    logic hsync;
    logic vsync;
    logic next_frame;
  } vga_timing_t;

  localparam vga_timing_t TIMING_RESET = '{
    x: '0, y: '0, active: 1'b0, hsync: 1'b1, vsync: 1'b1, next_frame: 1'b0
  };

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, once-per-frame debounce counter and
// rising-edge press pulse (combinational, valid in the strobe cycle).
module btn_debounce
  import vga_pkg::*;
#(
  parameter int unsigned FRAMES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_c_o
);

  localparam int unsigned CW = 4;

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hit_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any frame sample matching the accepted level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    hit_c   = (cnt_q == CW'(FRAMES - 1));
    if (sample_i) begin
      if (sync_q[1] != level_q) begin
        if (hit_c) begin
          level_d = sync_q[1];
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  assign level_o   = level_q;
  assign press_c_o = sample_i & sync_q[1] & ~level_q & hit_c;

endmodule

// File: rtl/vga_frame_ctrl.sv
// VGA raster counter with registered sync/active/next_frame decode and a
// button-driven, frame-synchronous animation step size.
module vga_frame_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 4,
  parameter step_t       STEP_RESET      = 3'd2,
  parameter int unsigned H_VIS           = H_VISIBLE,
  parameter int unsigned H_FP            = H_FRONT,
  parameter int unsigned H_SW            = H_SYNC,
  parameter int unsigned H_BP            = H_BACK,
  parameter int unsigned V_VIS           = V_VISIBLE,
  parameter int unsigned V_FP            = V_FRONT,
  parameter int unsigned V_SW            = V_SYNC,
  parameter int unsigned V_BP            = V_BACK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             active,
  output logic             hsync,
  output logic             vsync,
  output logic             next_frame,
  output step_t            step_size
);

  localparam int unsigned H_TOT  = H_VIS + H_FP + H_SW + H_BP;
  localparam int unsigned V_TOT  = V_VIS + V_FP + V_SW + V_BP;
  localparam int unsigned HS_BEG = H_VIS + H_FP;
  localparam int unsigned HS_END = HS_BEG + H_SW;
  localparam int unsigned VS_BEG = V_VIS + V_FP;
  localparam int unsigned VS_END = VS_BEG + V_SW;

  vga_timing_t tim_q, tim_d;
  step_t       step_q, step_d;
  logic        up_press_c, down_press_c;
  logic        up_level_unused, down_level_unused;

  // Decode flags from the next counter value so they line up with x/y.
  always_comb begin
    tim_d   = tim_q;
    tim_d.x = tim_q.x + cnt_t'(1);
    if (tim_q.x == cnt_t'(H_TOT - 1)) begin
      tim_d.x = '0;
      tim_d.y = (tim_q.y == cnt_t'(V_TOT - 1)) ? '0 : tim_q.y + cnt_t'(1);
    end
    tim_d.active     = (tim_d.x < cnt_t'(H_VIS)) && (tim_d.y < cnt_t'(V_VIS));
    tim_d.hsync      = !((tim_d.x >= cnt_t'(HS_BEG)) && (tim_d.x < cnt_t'(HS_END)));
    tim_d.vsync      = !((tim_d.y >= cnt_t'(VS_BEG)) && (tim_d.y < cnt_t'(VS_END)));
    tim_d.next_frame = (tim_d.x == '0) && (tim_d.y == cnt_t'(V_VIS));
  end

  // Presses only occur in the next_frame cycle, so step_size moves once per frame.
  always_comb begin
    step_d = step_q;
    if (up_press_c && !down_press_c && (step_q != STEP_MAX)) begin
      step_d = step_q + step_t'(1);
    end else if (down_press_c && !up_press_c && (step_q != '0)) begin
      step_d = step_q - step_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tim_q  <= TIMING_RESET;
      step_q <= STEP_RESET;
    end else begin
      tim_q  <= tim_d;
      step_q <= step_d;
    end
  end

  btn_debounce #(.FRAMES(DEBOUNCE_FRAMES)) u_btn_up (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_i  (tim_q.next_frame),
    .btn_i     (btn_up),
    .level_o   (up_level_unused),
    .press_c_o (up_press_c)
  );

  btn_debounce #(.FRAMES(DEBOUNCE_FRAMES)) u_btn_down (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_i  (tim_q.next_frame),
    .btn_i     (btn_down),
    .level_o   (down_level_unused),
    .press_c_o (down_press_c)
  );

  assign x          = tim_q.x;
  assign y          = tim_q.y;
  assign active     = tim_q.active;
  assign hsync      = tim_q.hsync;
  assign vsync      = tim_q.vsync;
  assign next_frame = tim_q.next_frame;
  assign step_size  = step_q;

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Bench for vga_frame_ctrl on a shrunken raster (16x12 clocks per frame) so that
// debounce and saturation scenarios spanning many frames stay short.
module tb_vga_frame_ctrl;

  localparam int HV = 8, HF = 2, HS = 4, HB = 2;
  localparam int VV = 6, VF = 2, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0, rst_n = 1'b1, btn_up = 1'b0, btn_down = 1'b0;
  logic [9:0] x, y;
  logic       active, hsync, vsync, next_frame;
  logic [2:0] step_size;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit up;
    bit dn;
    int frames;
    int exp_step;
  } row_t;

  row_t rows[$];
  int   exp_q[$];
  int   nf_times[$];

  always #5 clk = ~clk;

  vga_frame_ctrl #(
    .DEBOUNCE_FRAMES(4), .STEP_RESET(3'd2),
    .H_VIS(HV), .H_FP(HF), .H_SW(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SW(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
    .x(x), .y(y), .active(active), .hsync(hsync), .vsync(vsync),
    .next_frame(next_frame), .step_size(step_size)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      tick();
      n++;
    end while (next_frame !== 1'b1 && n < FRAME + 8);
    check("next_frame_within_budget", int'(next_frame === 1'b1), 1);
  endtask

  task automatic add_row(input bit up, input bit dn, input int frames, input int e);
    row_t r;
    r.up = up; r.dn = dn; r.frames = frames; r.exp_step = e;
    rows.push_back(r);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_x"}, int'(x), 0);
    check({tag, "_y"}, int'(y), 0);
    check({tag, "_hsync"}, int'(hsync), 1);
    check({tag, "_vsync"}, int'(vsync), 1);
    check({tag, "_active"}, int'(active), 0);
    check({tag, "_next_frame"}, int'(next_frame), 0);
    check({tag, "_step"}, int'(step_size), 2);
  endtask

  // Expected raster outputs n clocks after reset release.
  function automatic int exp_vec(input int n);
    int xv, yv, a, h, v, nf;
    xv = n % HT;
    yv = (n / HT) % VT;
    a  = (xv < HV && yv < VV) ? 1 : 0;
    h  = (xv >= HV + HF && xv < HV + HF + HS) ? 0 : 1;
    v  = (yv >= VV + VF && yv < VV + VF + VS) ? 0 : 1;
    nf = (xv == 0 && yv == VV) ? 1 : 0;
    return (xv << 14) | (yv << 4) | (h << 3) | (v << 2) | (a << 1) | nf;
  endfunction

  // step_size may only move in the cycle right after a next_frame pulse.
  logic [2:0] prev_step = 3'd0;
  bit         prev_nf = 1'b0, prev_rst = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rst_n && prev_rst && step_size != prev_step) begin
      total++;
      if (!prev_nf) begin
        bad++;
        $display("FAIL step_change_timing: got change %0d->%0d without preceding next_frame at t=%0t",
                 prev_step, step_size, $time);
      end
    end
    prev_step = step_size;
    prev_nf   = next_frame;
    prev_rst  = rst_n;
  end

  initial begin
    int act_cnt, hs_cnt, vs_cnt, n, e;

    // Step sequences: start at 3 with both buttons released.
    add_row(1, 0, 3, 3); add_row(0, 0, 2, 3);
    add_row(1, 0, 3, 3); add_row(0, 0, 2, 3);
    for (int i = 0; i < 6; i++) begin
      e = (4 + i > 7) ? 7 : 4 + i;
      add_row(1, 0, 4, e); add_row(0, 0, 4, e);
    end
    for (int i = 0; i < 9; i++) begin
      e = (6 - i < 0) ? 0 : 6 - i;
      add_row(0, 1, 4, e); add_row(0, 0, 4, e);
    end
    add_row(1, 0, 4, 1); add_row(0, 0, 4, 1);
    add_row(1, 1, 4, 1); add_row(0, 0, 4, 1);

    #1 rst_n = 1'b0;
    #1 check_reset_values("por");
    repeat (3) tick();
    check_reset_values("por_clocked");

    @(negedge clk) rst_n = 1'b1;
    act_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    for (int k = 1; k <= 2 * FRAME + HT * VV; k++) begin
      tick();
      check("raster", int'({x, y, hsync, vsync, active, next_frame}), exp_vec(k));
      if (k == 1) begin
        check("first_edge_x", int'(x), 1);
        check("first_edge_y", int'(y), 0);
        check("first_edge_active", int'(active), 1);
      end
      if (next_frame) nf_times.push_back(k);
      if (k >= FRAME && k < 2 * FRAME) begin
        act_cnt += int'(active);
        hs_cnt  += int'(!hsync);
        vs_cnt  += int'(!vsync);
      end
    end
    check("active_per_frame", act_cnt, HV * VV);
    check("hsync_low_per_frame", hs_cnt, HS * VT);
    check("vsync_low_per_frame", vs_cnt, VS * HT);
    check("next_frame_count", nf_times.size(), 3);
    if (nf_times.size() == 3) begin
      check("next_frame_first", nf_times[0], HT * VV);
      check("next_frame_period_a", nf_times[1] - nf_times[0], FRAME);
      check("next_frame_period_b", nf_times[2] - nf_times[1], FRAME);
    end

    // Held up button: accepted on the 4th frame sample, no auto-repeat.
    tick();
    btn_up = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      wait_frame();
      tick();
      check("hold_before_accept", int'(step_size), 2);
    end
    wait_frame();
    check("hold_in_strobe_cycle", int'(step_size), 2);
    tick();
    check("hold_accepted", int'(step_size), 3);
    repeat (20) wait_frame();
    tick();
    check("hold_no_repeat", int'(step_size), 3);
    btn_up = 1'b0;
    repeat (4) wait_frame();
    tick();
    check("release", int'(step_size), 3);

    foreach (rows[i]) begin
      exp_q.push_back(rows[i].exp_step);
      btn_up   = rows[i].up;
      btn_down = rows[i].dn;
      repeat (rows[i].frames) wait_frame();
      tick();
      check($sformatf("table_row%0d", i), int'(step_size), exp_q.pop_front());
    end

    // Reset in the middle of a frame while an up press is half debounced.
    btn_up = 1'b1;
    repeat (2) wait_frame();
    n = 0;
    while (!(x == 10'(HV / 2) && y == 10'(VV / 2)) && n < FRAME + 8) begin
      tick();
      n++;
    end
    check("reach_midframe", int'(x == 10'(HV / 2) && y == 10'(VV / 2)), 1);
    @(negedge clk) rst_n = 1'b0;
    #1 check_reset_values("midframe_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rerelease_x", int'(x), 1);
    check("rerelease_y", int'(y), 0);
    check("rerelease_active", int'(active), 1);
    repeat (3) wait_frame();
    tick();
    check("partial_count_discarded", int'(step_size), 2);
    wait_frame();
    tick();
    check("fresh_count_completes", int'(step_size), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
